// File: rtl/bus_xfer_arbiter.sv
// Round-robin arbiter that sequences register-to-register moves on a shared
// tristate data bus: one DRIVE cycle to let the source settle, then one
// COMMIT cycle in which the destination latches and the requester gets done.
module bus_xfer_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned REQ_IDX_W = 2,
    parameter int unsigned NUM_REG   = 6,
    parameter int unsigned REG_IDX_W = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*REG_IDX_W-1:0] req_src,
    input  logic [NUM_REQ*REG_IDX_W-1:0] req_dst,
    output logic [NUM_REQ-1:0]           req_done,
    output logic                         req_err,
    output logic [NUM_REG-1:0]           reg_read_en,
    output logic [NUM_REG-1:0]           reg_write_en,
    output logic                         busy,
    output logic [REQ_IDX_W-1:0]         grant_id
);

    typedef enum logic [1:0] {StIdle, StDrive, StCommit} state_e;

    state_e                 state_q, state_d;
    logic [REQ_IDX_W-1:0]   ptr_q, ptr_d;
    logic [REQ_IDX_W-1:0]   grant_q, grant_d;
    logic [REG_IDX_W-1:0]   src_q, src_d;
    logic [REG_IDX_W-1:0]   dst_q, dst_d;
    logic                   err_q, err_d;

    logic [NUM_REQ-1:0]     eligible;
    logic                   found;
    logic [REQ_IDX_W-1:0]   win;
    logic [REG_IDX_W-1:0]   win_src, win_dst;
    logic                   win_err;

    // Mask the current grantee in COMMIT so a stale valid cannot win again.
    always_comb begin
        eligible = req_valid;
        if (state_q == StCommit) begin
            eligible[grant_q] = 1'b0;
        end
    end

    // Round-robin search starting at the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        logic [REQ_IDX_W:0]   sum;
        logic [REQ_IDX_W-1:0] cand;
        found = 1'b0;
        win   = '0;
        sum   = '0;
        cand  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr_q} + (REQ_IDX_W + 1)'(k);
            if (sum >= (REQ_IDX_W + 1)'(NUM_REQ)) begin
                sum = sum - (REQ_IDX_W + 1)'(NUM_REQ);
            end
            cand = sum[REQ_IDX_W-1:0];
            if (!found && eligible[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Select the winner's operands and flag out-of-range indices.
    always_comb begin
        win_src = '0;
        win_dst = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win == REQ_IDX_W'(i)) begin
                win_src = req_src[i*REG_IDX_W +: REG_IDX_W];
                win_dst = req_dst[i*REG_IDX_W +: REG_IDX_W];
            end
        end
        win_err = (32'(win_src) >= NUM_REG) || (32'(win_dst) >= NUM_REG);
    end

    // State and latched transfer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            grant_q <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            err_q   <= err_d;
        end
    end

    // Next-state: grant in IDLE or COMMIT, DRIVE always advances to COMMIT.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        src_d   = src_q;
        dst_d   = dst_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle, StCommit: begin
                if (found) begin
                    state_d = StDrive;
                    grant_d = win;
                    src_d   = win_src;
                    dst_d   = win_dst;
                    err_d   = win_err;
                    ptr_d   = (win == REQ_IDX_W'(NUM_REQ - 1)) ? '0 : win + REQ_IDX_W'(1);
                end else begin
                    state_d = StIdle;
                end
            end
            StDrive: state_d = StCommit;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decode only from registered state; an erroring transfer drives nothing.
    always_comb begin
        reg_read_en  = '0;
        reg_write_en = '0;
        req_done     = '0;
        req_err      = 1'b0;
        busy         = 1'b0;
        case (state_q)
            StDrive: begin
                busy = 1'b1;
                if (!err_q) begin
                    for (int unsigned i = 0; i < NUM_REG; i++) begin
                        reg_read_en[i] = (src_q == REG_IDX_W'(i));
                    end
                end
            end
            StCommit: begin
                busy              = 1'b1;
                req_done[grant_q] = 1'b1;
                req_err           = err_q;
                if (!err_q) begin
                    for (int unsigned i = 0; i < NUM_REG; i++) begin
                        reg_read_en[i]  = (src_q == REG_IDX_W'(i));
                        reg_write_en[i] = (dst_q == REG_IDX_W'(i));
                    end
                end
            end
            default: ;
        endcase
    end

    assign grant_id = grant_q;

endmodule

// File: tb/tb_bus_xfer_arbiter.sv
// Bench for bus_xfer_arbiter: directed scenarios with literal expectations,
// then randomized requesters, all checked every cycle against a transfer-level model.
module tb_bus_xfer_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int REQ_IDX_W = 2;
    localparam int NUM_REG   = 6;
    localparam int REG_IDX_W = 3;

    logic                         clk;
    logic                         rst;
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*REG_IDX_W-1:0] req_src;
    logic [NUM_REQ*REG_IDX_W-1:0] req_dst;
    logic [NUM_REQ-1:0]           req_done;
    logic                         req_err;
    logic [NUM_REG-1:0]           reg_read_en;
    logic [NUM_REG-1:0]           reg_write_en;
    logic                         busy;
    logic [REQ_IDX_W-1:0]         grant_id;

    int n_checks = 0;
    int n_errors = 0;

    bus_xfer_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .REQ_IDX_W(REQ_IDX_W),
        .NUM_REG  (NUM_REG),
        .REG_IDX_W(REG_IDX_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_src     (req_src),
        .req_dst     (req_dst),
        .req_done    (req_done),
        .req_err     (req_err),
        .reg_read_en (reg_read_en),
        .reg_write_en(reg_write_en),
        .busy        (busy),
        .grant_id    (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- transfer-level reference model ----------------
    // age 0: no transfer, 1: source settling on the bus, 2: destination latching.
    int       m_age = 0;
    int       m_ptr = 0;
    int       m_gid = 0;
    int       m_src = 0;
    int       m_dst = 0;
    bit       m_err = 0;
    bit       m_ok  = 0;

    always @(negedge clk) begin
        logic [NUM_REG-1:0] e_rd, e_wr;
        logic [NUM_REQ-1:0] e_done;
        bit                 fnd;
        int                 pick;
        if (m_ok) begin
            e_rd   = '0;
            e_wr   = '0;
            e_done = '0;
            if (m_age > 0 && !m_err) e_rd[m_src] = 1'b1;
            if (m_age == 2 && !m_err) e_wr[m_dst] = 1'b1;
            if (m_age == 2) e_done[m_gid] = 1'b1;
            chk("read_en", 32'(reg_read_en), 32'(e_rd));
            chk("write_en", 32'(reg_write_en), 32'(e_wr));
            chk("done", 32'(req_done), 32'(e_done));
            chk("err", 32'(req_err), 32'(m_age == 2 && m_err));
            chk("busy", 32'(busy), 32'(m_age != 0));
            chk("grant_id", 32'(grant_id), 32'(m_gid));
            chk("inv_read_le1", 32'($countones(reg_read_en) <= 1), 32'd1);
            chk("inv_write_le1", 32'($countones(reg_write_en) <= 1), 32'd1);
            chk("inv_done_le1", 32'($countones(req_done) <= 1), 32'd1);
            chk("inv_write_needs_read",
                32'((reg_write_en == '0) || (reg_read_en != '0)), 32'd1);
        end
        // Advance the model using the inputs the next clock edge will sample.
        if (rst) begin
            m_age = 0;
            m_ptr = 0;
            m_gid = 0;
            m_ok  = 1;
        end else if (m_age == 1) begin
            m_age = 2;
        end else begin
            fnd  = 0;
            pick = 0;
            for (int k = 0; k < NUM_REQ; k++) begin
                int idx;
                idx = (m_ptr + k) % NUM_REQ;
                if (!fnd && req_valid[idx] && !(m_age == 2 && idx == m_gid)) begin
                    fnd  = 1;
                    pick = idx;
                end
            end
            if (fnd) begin
                m_gid = pick;
                m_src = int'(req_src[pick*REG_IDX_W +: REG_IDX_W]);
                m_dst = int'(req_dst[pick*REG_IDX_W +: REG_IDX_W]);
                m_err = (m_src >= NUM_REG) || (m_dst >= NUM_REG);
                m_ptr = (pick + 1) % NUM_REQ;
                m_age = 1;
            end else begin
                m_age = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] s, input logic [2:0] d);
        req_src[i*REG_IDX_W +: REG_IDX_W] = s;
        req_dst[i*REG_IDX_W +: REG_IDX_W] = d;
    endtask

    task automatic do_reset();
        tick();
        rst       = 1'b1;
        req_valid = '0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [NUM_REQ-1:0] done_prev;
        rst       = 1'b1;
        req_valid = '0;
        req_src   = '0;
        req_dst   = '0;

        // Single transfer, also pins the reset state.
        do_reset();
        set_req(0, 3'd1, 3'd3);
        req_valid = 4'b0001;
        @(negedge clk);
        chk("rst_read", 32'(reg_read_en), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_grant", 32'(grant_id), 32'h0);
        chk("rst_done", 32'(req_done), 32'h0);
        @(negedge clk);
        chk("single_drive_read", 32'(reg_read_en), 32'b000010);
        chk("single_drive_write", 32'(reg_write_en), 32'h0);
        @(negedge clk);
        chk("single_commit_read", 32'(reg_read_en), 32'b000010);
        chk("single_commit_write", 32'(reg_write_en), 32'b001000);
        chk("single_commit_done", 32'(req_done), 32'b0001);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("single_after_read", 32'(reg_read_en), 32'h0);
        chk("single_after_busy", 32'(busy), 32'h0);

        // Round-robin with everyone valid.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 3'(i), 3'(i + 2));
        req_valid = 4'b1111;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rr_busy_drive", 32'(busy), 32'h1);
            @(negedge clk);
            chk("rr_done_order", 32'(req_done), 32'(1 << (k % NUM_REQ)));
            chk("rr_busy_commit", 32'(busy), 32'h1);
        end
        tick();
        req_valid = '0;
        repeat (3) tick();

        // Mask after grant: stale valid in COMMIT does not re-grant.
        do_reset();
        set_req(2, 3'd0, 3'd5);
        req_valid = 4'b0100;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("mask_done", 32'(req_done), 32'b0100);
        tick();
        @(negedge clk);
        chk("mask_idle_busy", 32'(busy), 32'h0);
        chk("mask_idle_read", 32'(reg_read_en), 32'h0);
        @(negedge clk);
        chk("mask_regrant_busy", 32'(busy), 32'h1);
        chk("mask_regrant_read", 32'(reg_read_en), 32'b000001);
        chk("mask_regrant_id", 32'(grant_id), 32'd2);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("mask_second_done", 32'(req_done), 32'b0100);

        // Illegal source index.
        do_reset();
        set_req(1, 3'd7, 3'd2);
        req_valid = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        chk("ill_drive_read", 32'(reg_read_en), 32'h0);
        chk("ill_drive_busy", 32'(busy), 32'h1);
        @(negedge clk);
        chk("ill_commit_read", 32'(reg_read_en), 32'h0);
        chk("ill_commit_write", 32'(reg_write_en), 32'h0);
        chk("ill_commit_done", 32'(req_done), 32'b0010);
        chk("ill_commit_err", 32'(req_err), 32'h1);
        tick();
        req_valid = '0;

        // Reset during DRIVE of req3, then req0 wins over req3.
        do_reset();
        set_req(3, 3'd4, 3'd1);
        set_req(0, 3'd1, 3'd2);
        req_valid = 4'b1000;
        @(negedge clk);
        tick();
        rst       = 1'b1;
        req_valid = 4'b1001;
        @(negedge clk);
        chk("rstmid_drive_read", 32'(reg_read_en), 32'b010000);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_read", 32'(reg_read_en), 32'h0);
        chk("rstmid_done", 32'(req_done), 32'h0);
        chk("rstmid_busy", 32'(busy), 32'h0);
        chk("rstmid_grant", 32'(grant_id), 32'h0);
        @(negedge clk);
        chk("rstmid_first_grant", 32'(grant_id), 32'h0);
        chk("rstmid_first_read", 32'(reg_read_en), 32'b000010);
        @(negedge clk);
        chk("rstmid_first_done", 32'(req_done), 32'b0001);
        tick();
        req_valid = 4'b1000;
        @(negedge clk);
        chk("rstmid_second_grant", 32'(grant_id), 32'd3);
        chk("rstmid_second_read", 32'(reg_read_en), 32'b010000);
        @(negedge clk);
        chk("rstmid_second_done", 32'(req_done), 32'b1000);
        tick();
        req_valid = '0;

        // Operand change after grant is ignored.
        do_reset();
        set_req(0, 3'd2, 3'd4);
        req_valid = 4'b0001;
        @(negedge clk);
        tick();
        set_req(0, 3'd5, 3'd4);
        @(negedge clk);
        chk("stale_drive_read", 32'(reg_read_en), 32'b000100);
        @(negedge clk);
        chk("stale_commit_read", 32'(reg_read_en), 32'b000100);
        chk("stale_commit_write", 32'(reg_write_en), 32'b010000);
        chk("stale_commit_done", 32'(req_done), 32'b0001);
        tick();
        req_valid = '0;

        // Randomized requesters; the model process does the checking.
        do_reset();
        done_prev = '0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            rst = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (done_prev[i]) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        req_valid[i] = 1'b1;
                        set_req(i, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
                    end
                end else begin
                    if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
                    if ($urandom_range(0, 7) == 0) begin
                        set_req(i, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
                    end
                end
            end
            done_prev = req_done;
        end
        rst       = 1'b0;
        req_valid = '0;
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bus_xfer_arbiter.md
Name: bus_xfer_arbiter

Overview:
- Sequences register-to-register moves on the shared 8-bit tristate data bus.
- Drives the read_en and write_en strobes of the bus registers.
- Arbitrates round-robin between several requesters (e.g. control unit, debug port, interrupt logic).
- Guarantees at most one register drives the bus at any time, and that a destination only latches after its source has driven the bus for a full settle cycle.

Parameters:
- NUM_REQ, 4: number of requesters.
- REQ_IDX_W, 2: width of the requester index; must equal clog2(NUM_REQ).
- NUM_REG, 6: number of bus registers under control.
- REG_IDX_W, 3: width of a register index.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester transfer request.
- req_src  in  NUM_REQ*REG_IDX_W  packed source register index; slot i is bits [i*REG_IDX_W +: REG_IDX_W].
- req_dst  in  NUM_REQ*REG_IDX_W  packed destination register index, same packing as req_src.
- req_done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- req_err  out  1  one-cycle pulse, coincident with req_done, when the completed request had an illegal index.
- reg_read_en  out  NUM_REG  one-hot-or-zero bus drive enables.
- reg_write_en  out  NUM_REG  one-hot-or-zero latch enables.
- busy  out  1  high in DRIVE and COMMIT.
- grant_id  out  REQ_IDX_W  index of the current/last granted requester.

Behaviour:
- States: IDLE, DRIVE, COMMIT. All outputs decode from registered state, latched src/dst/grant and the err flag only. There is no combinational path from req_* inputs to outputs.
- Reset (takes effect at the next clk edge, including mid-transfer):
  - state goes to IDLE; round-robin pointer goes to 0; grant_id = 0.
  - reg_read_en = 0, reg_write_en = 0, req_done = 0, req_err = 0, busy = 0.
  - An aborted transfer produces no done pulse.
- Arbitration (evaluated in IDLE and COMMIT):
  - Search starts at the pointer and proceeds upward modulo NUM_REQ; the first requester with valid set wins.
  - In COMMIT the currently granted requester is masked out, so it cannot be re-granted back-to-back on a stale valid.
  - On a grant, latch grant_id, src, dst and err at the clock edge. err = (src >= NUM_REG) or (dst >= NUM_REG).
  - Pointer becomes winner+1 (wraps).
- IDLE: if any eligible valid, go to DRIVE; else stay.
- DRIVE (1 cycle):
  - reg_read_en[src] = 1, unless err, in which case no enables.
  - Next state is COMMIT.
- COMMIT (1 cycle):
  - reg_read_en[src] = 1 and reg_write_en[dst] = 1; the destination latches at the end of this cycle.
  - req_done[grant_id] = 1; req_err = err.
  - If err: no enables are asserted.
  - If another eligible requester is valid, go directly to DRIVE with the new grant; else go to IDLE.
- Throughput:
  - Latency from valid sampled in IDLE to done: 2 cycles (DRIVE, COMMIT).
  - Sustained rate: one transfer per 2 cycles.
  - reg_read_en changes source only across a COMMIT→DRIVE edge, so no two drivers ever overlap.
- src == dst: legal; the register rewrites its own value; normal sequencing.
- Requester obligations and capture rules:
  - Requesters hold valid until they see done and drop valid the cycle after done.
  - src/dst changes after the grant are ignored.
  - A valid dropped before its grant is simply not served.
- Invariants, checked every cycle:
  - popcount(reg_read_en) ≤ 1; popcount(reg_write_en) ≤ 1; popcount(req_done) ≤ 1.
  - reg_write_en is nonzero only in COMMIT.
  - When reg_write_en is nonzero, reg_read_en is also nonzero.

Test Plan:
- Single transfer: req0 valid, src=1, dst=3 from IDLE.
  - Cycle+1: read_en = 6'b000010, write_en = 0.
  - Cycle+2: read_en = 6'b000010, write_en = 6'b001000, done = 4'b0001.
  - Cycle+3: all zero, IDLE.
- Round-robin: req0..3 all valid continuously with distinct src/dst.
  - Done pulses in order 0,1,2,3,0 at 2-cycle spacing; busy held high throughout.
- Mask after grant: only req2 valid and it drops valid one cycle late (still high in COMMIT).
  - No re-grant in that COMMIT; next state is IDLE; req2 served again only on the following IDLE sample.
- Illegal index: req1 src=7 with NUM_REG=6.
  - No read_en/write_en asserted in either cycle; done = 4'b0010 and req_err = 1 in COMMIT.
- Reset mid-operation: assert rst during DRIVE of req3.
  - Next cycle all outputs are 0, state IDLE, no done pulse.
  - With req0 and req3 then both valid, req0 is granted first (pointer = 0).
- Stale operand change: req0 granted with src=2, dst=4; change src to 5 during DRIVE.
  - COMMIT still shows read_en = 6'b000100 and write_en = 6'b010000.
